// File: rtl/difftest_step_gen.sv
// Purpose : batches per-cycle commit-valid lanes into difftest step counts for the co-sim harness.
// Latency : 1 cycle; an emit edge drives difftest_step for exactly the following cycle.
// Backpressure: none; the harness must accept every nonzero step, and commits are never stalled.
//
// Ports:
//   clock         - sole clock, rising edge
//   reset         - asynchronous, active-high; discards any pending count without emitting
//   commit_valid  - one bit per instruction committed this cycle
//   flush         - trap / end-of-run; forces an emit of everything pending and halts the block
//   difftest_step - registered commit count, nonzero only in the cycle after an emit
//   pending       - registered accumulated count not yet handed to the harness
//   halted        - registered, set once a flush has been emitted, cleared only by reset
module difftest_step_gen #(
  parameter int COMMIT_WIDTH = 8,
  parameter int STEP_WIDTH   = 8,
  parameter int BATCH_THRESH = 64,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COMMIT_WIDTH-1:0] commit_valid,
  input  logic                    flush,
  output logic [STEP_WIDTH-1:0]   difftest_step,
  output logic [STEP_WIDTH-1:0]   pending,
  output logic                    halted
);

  // Timer only ever needs to reach TIMEOUT-1.
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam longint STEP_MAX = (longint'(1) << STEP_WIDTH) - 1;

  // pending < BATCH_THRESH outside an emit, so pending + popcount stays below
  // BATCH_THRESH + COMMIT_WIDTH; that bound must fit in STEP_WIDTH bits.
  if (longint'(BATCH_THRESH) + longint'(COMMIT_WIDTH) > STEP_MAX) begin : g_bad_widths
    $error("difftest_step_gen: BATCH_THRESH + COMMIT_WIDTH exceeds 2^STEP_WIDTH - 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("difftest_step_gen: TIMEOUT must be at least 1");
  end

  localparam logic [STEP_WIDTH-1:0] THRESH_V   = STEP_WIDTH'(BATCH_THRESH);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [TIMER_W-1:0]    timer, timer_nxt;
  logic [STEP_WIDTH-1:0] step_nxt, pending_nxt;
  logic                  halted_nxt;
  logic [STEP_WIDTH-1:0] cnt;
  logic [STEP_WIDTH-1:0] total;
  logic                  emit;

  // Popcount of this cycle's commits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      cnt = cnt + STEP_WIDTH'(commit_valid[i]);
    end
  end

  // Commits on the current edge always join the running count, so an emit on
  // this edge carries them and nothing is dropped or counted twice.
  assign total = pending + cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      difftest_step <= '0;
      pending       <= '0;
      halted        <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      difftest_step <= step_nxt;
      pending       <= pending_nxt;
      halted        <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    step_nxt    = '0;
    pending_nxt = pending;
    halted_nxt  = halted;
    emit        = 1'b0;

    case (state)
      S_IDLE, S_ACCUM: begin
        // Threshold, timeout and flush all collapse into one emit of total.
        emit = flush || (total >= THRESH_V) ||
               ((state == S_ACCUM) && (timer == TIMER_LAST));
        if (emit) begin
          step_nxt    = total;
          pending_nxt = '0;
          timer_nxt   = '0;
          if (flush) begin
            state_nxt  = S_HALT;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (state == S_IDLE) begin
          if (cnt != '0) begin
            pending_nxt = total;
            timer_nxt   = '0;
            state_nxt   = S_ACCUM;
          end
        end else begin
          // No emit in ACCUM means timer < TIMEOUT-1, so the increment cannot wrap.
          // The timer keeps running across new commits: it bounds the age of the oldest one.
          pending_nxt = total;
          timer_nxt   = timer + TIMER_W'(1);
        end
      end
      S_HALT: begin
        pending_nxt = '0;
        timer_nxt   = '0;
        halted_nxt  = 1'b1;
      end
      default: begin
        state_nxt   = S_IDLE;
        pending_nxt = '0;
        timer_nxt   = '0;
      end
    endcase
  end

endmodule
